// File: rtl/divider_seq_pkg.sv
// Shared constants for the sequential signed divider: state encoding and default width.
package divider_seq_pkg;

    localparam int DIV_WIDTH = 8;

    // Most negative operand value, the only dividend that can overflow the quotient.
    localparam logic [DIV_WIDTH-1:0] MIN_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational.
module div_step
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   pr_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   pr_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One guard bit above the partial remainder makes the borrow the sign of the trial result.
    assign shifted = {pr_in, dvd_bit};
    assign diff    = shifted - {2'b00, dsr};
    assign q_bit   = ~diff[WIDTH+1];
    assign pr_out  = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle signed divider (restoring, one quotient bit per cycle) with start/done handshake.
// Define DIVIDER_SAT_EN to saturate the quotient on overflow instead of wrapping.
module divider_seq
    import divider_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             dz
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr;
    logic [WIDTH:0]   pr_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             sign_q;
    logic             sign_r;
    logic             dz_pend;
    logic             ovf_pend;
    logic             q_bit;
    logic             load_div;
    logic             load_dz;
    logic             step_en;
    logic             fix_en;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (b == '0) ? FIX : DIV;
            DIV:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        load_div = (state == IDLE) && start && (b != '0);
        load_dz  = (state == IDLE) && start && (b == '0);
        step_en  = (state == DIV);
        fix_en   = (state == FIX);
    end

    // Magnitudes are unsigned, so negating the most negative value still fits.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_in   (pr),
        .dvd_bit (dvd[WIDTH-1]),
        .dsr     (dsr),
        .pr_out  (pr_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        q_fix = sign_q ? -dvd : dvd;
`ifdef DIVIDER_SAT_EN
        if (ovf_pend) q_fix = ~MIN_NEG_W;
`endif
        r_fix = sign_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
    end

    // The dividend register shifts out dividend bits while shifting in quotient bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pr       <= '0;
            dvd      <= '0;
            dsr      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_div) begin
                dvd      <= a_mag;
                dsr      <= b_mag;
                pr       <= '0;
                cnt      <= CW'(WIDTH - 1);
                sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                sign_r   <= a[WIDTH-1];
                dz_pend  <= 1'b0;
                ovf_pend <= (a == MIN_NEG_W) && (b == '1);
                ovf      <= 1'b0;
                dz       <= 1'b0;
            end else if (load_dz) begin
                dvd      <= a;
                dz_pend  <= 1'b1;
                ovf_pend <= 1'b0;
                ovf      <= 1'b0;
                dz       <= 1'b0;
            end
            if (step_en) begin
                pr  <= pr_nxt;
                dvd <= {dvd[WIDTH-2:0], q_bit};
                cnt <= cnt - CW'(1);
            end
            if (fix_en) begin
                done <= 1'b1;
                dz   <= dz_pend;
                ovf  <= ovf_pend;
                if (dz_pend) begin
                    quot <= '0;
                    rem  <= dvd;
                end else begin
                    quot <= q_fix;
                    rem  <= r_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed corner cases plus random operands against an arithmetic model.
module tb_divider_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dz;

    int total = 0;
    int bad   = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // SV integer division truncates toward zero and % follows the dividend's sign.
    function automatic void ref_div(input int av, input int bv, output int q, output int r,
                                    output bit o, output bit z);
        o = 1'b0;
        z = 1'b0;
        if (bv == 0) begin
            z = 1'b1;
            q = 0;
            r = av;
        end else if (av == -128 && bv == -1) begin
            o = 1'b1;
`ifdef DIVIDER_SAT_EN
            q = 127;
`else
            q = -128;
`endif
            r = 0;
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    // Called at posedge+1; start is raised in the current cycle, returns in the done cycle.
    task automatic run_div(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                           input bit poke);
        int q, r, lat, exp_lat;
        bit o, z, busy_ok;
        logic [7:0] qe, re;
        string op;
        ref_div(int'(av), int'(bv), q, r, o, z);
        qe = q[7:0];
        re = r[7:0];
        op = $sformatf("%0d/%0d", av, bv);
        exp_lat = z ? 2 : W + 2;
        a = av;
        b = bv;
        start = 1'b1;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) start = 1'b0;
            if (!done && busy !== 1'b1) busy_ok = 1'b0;
            if (poke && lat == 3) begin
                start = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if (poke && lat == 4) start = 1'b0;
        end while (!done && lat < 20);
        check({"lat ", op}, 32'(lat), 32'(exp_lat));
        check({"busy_run ", op}, 32'(busy_ok), 32'd1);
        check({"busy_done ", op}, 32'(busy), 32'd0);
        check({"quot ", op}, 32'(quot), 32'(qe));
        check({"rem ", op}, 32'(rem), 32'(re));
        check({"ovf ", op}, 32'(ovf), 32'(o));
        check({"dz ", op}, 32'(dz), 32'(z));
    endtask

    initial begin
        logic signed [W-1:0] ra, rb;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: each call raises start in the previous call's done cycle.
        run_div(8'sd100, 8'sd7, 1'b0);
        run_div(-8'sd100, 8'sd7, 1'b0);
        run_div(8'sd100, -8'sd7, 1'b0);
        run_div(-8'sd100, -8'sd7, 1'b0);
        run_div(8'sd5, 8'sd0, 1'b0);
        run_div(8'sd100, 8'sd7, 1'b0);
        run_div(-8'sd128, -8'sd1, 1'b0);
        run_div(8'sd3, 8'sd5, 1'b0);
        run_div(8'sd50, 8'sd3, 1'b1);
        run_div(8'sd127, -8'sd128, 1'b0);
        run_div(-8'sd128, 8'sd1, 1'b0);
        run_div(-8'sd128, -8'sd128, 1'b0);
        run_div(-8'sd128, 8'sd0, 1'b0);
        run_div(8'sd0, -8'sd5, 1'b0);
        run_div(-8'sd1, 8'sd127, 1'b0);

        // Abort a division with reset in its fifth cycle.
        a = 8'd77;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_quot", 32'(quot), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_div(-8'sd127, 8'sd2, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = -8'sd128; rb = -8'sd1; end
                2: rb = 8'($urandom_range(1, 3));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_div(ra, rb, ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
